// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: opcodes, write-back
// destinations, FSM state encoding and the operation legality check.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_SHR = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI = 5'b01110;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  localparam logic [4:0] OP_MIN = OP_ADD;
  localparam logic [4:0] OP_MAX = OP_NOT;

  localparam logic [1:0] DEST_GPR = 2'b00;
  localparam logic [1:0] DEST_LO  = 2'b01;
  localparam logic [1:0] DEST_HI  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_Y = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB_LO  = 3'd3,
    ST_WB_HI  = 3'd4
  } alu_state_e;

  // mul/div produce a 64-bit result returned as two beats.
  function automatic logic is_wide(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_legal(input logic [4:0] op, input logic [31:0] b,
                                    input logic div0_trap);
    logic in_range;
    in_range = (op >= OP_MIN) && (op <= OP_MAX);
    return in_range && !(div0_trap && (op == OP_DIV) && (b == 32'd0));
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, ALU-side and write-back signals of the ALU sequencer.
// Handshakes: a transfer happens on a rising edge where valid (start / wb_valid)
// and ready (start_ready / wb_ready) are both high; a presented beat holds stable until then.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic        start;
  logic        start_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [4:0]  alu_instruction;
  logic [31:0] alu_y;
  logic [31:0] alu_b;
  logic [31:0] alu_z_hi;
  logic [31:0] alu_z_lo;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [1:0]  wb_dest;
  logic        illegal;
  alu_state_e  dbg_state;

  modport master (
    output start, op, a, b, alu_z_hi, alu_z_lo, wb_ready,
    input  start_ready, busy, alu_instruction, alu_y, alu_b,
           wb_valid, wb_data, wb_dest, illegal, dbg_state
  );

  modport slave (
    input  start, op, a, b, alu_z_hi, alu_z_lo, wb_ready,
    output start_ready, busy, alu_instruction, alu_y, alu_b,
           wb_valid, wb_data, wb_dest, illegal, dbg_state
  );

endinterface

// File: rtl/z_capture_reg.sv
// 64-bit result register with load enable and asynchronous active-high clear.
module z_capture_reg (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [63:0] d,
  output logic [63:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 64'd0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control stage around the combinational ALU: accepts an op,
// loads Y, executes, captures Z and returns it over a ready/valid write-back port.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter bit DIV0_TRAP = 1'b1
) (
  input logic             clk,
  input logic             clr,
  alu_sequencer_if.slave  bus
);

  alu_state_e  state_q, state_d;
  logic [4:0]  op_q;
  logic [31:0] b_q;
  logic [31:0] y_q;
  logic [63:0] z_q;
  logic        accept;
  logic        wide_op;
  logic        op_ok;

  assign accept  = (state_q == ST_IDLE) && bus.start;
  assign wide_op = is_wide(op_q);
  assign op_ok   = op_legal(op_q, b_q, DIV0_TRAP);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      op_q    <= 5'd0;
      b_q     <= 32'd0;
      y_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= bus.op;
        b_q  <= bus.b;
        y_q  <= bus.a;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_LOAD_Y;
      ST_LOAD_Y: state_d = op_ok ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_d = ST_WB_LO;
      ST_WB_LO:  if (bus.wb_ready) state_d = wide_op ? ST_WB_HI : ST_IDLE;
      ST_WB_HI:  if (bus.wb_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Z takes the ALU output exactly as presented during EXEC.
  z_capture_reg u_z_capture_reg (
    .clk  (clk),
    .clr  (clr),
    .load (state_q == ST_EXEC),
    .d    ({bus.alu_z_hi, bus.alu_z_lo}),
    .q    (z_q)
  );

  // Every output is a decode of registered state/data only.
  always_comb begin
    bus.start_ready     = 1'b0;
    bus.busy            = 1'b1;
    bus.alu_instruction = 5'd0;
    bus.alu_b           = 32'd0;
    bus.wb_valid        = 1'b0;
    bus.wb_data         = 32'd0;
    bus.wb_dest         = DEST_GPR;
    bus.illegal         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.start_ready = 1'b1;
        bus.busy        = 1'b0;
      end
      ST_LOAD_Y: bus.illegal = !op_ok;
      ST_EXEC: begin
        bus.alu_instruction = op_q;
        bus.alu_b           = b_q;
      end
      ST_WB_LO: begin
        bus.wb_valid = 1'b1;
        bus.wb_data  = z_q[31:0];
        bus.wb_dest  = wide_op ? DEST_LO : DEST_GPR;
      end
      ST_WB_HI: begin
        bus.wb_valid = 1'b1;
        bus.wb_data  = z_q[63:32];
        bus.wb_dest  = DEST_HI;
      end
      default: ;
    endcase
  end

  assign bus.alu_y     = y_q;
  assign bus.dbg_state = state_q;

endmodule
